// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: streams one selected pixel source into a frame BRAM.
// Ports: clk/rst_n; frame_start_i, src_sel_i; pixel_i, pixel_en_i;
//   BRAM side ena_o, wea_o, addr_o, d2mem_o;
//   status busy_o, frame_done_o, collision_o, row_o, col_o.
module pixel_frame_writer #(
    parameter int NUM_SRC = 2,
    parameter int PIX_W   = 8,
    parameter int IMG_ROW = 540,
    parameter int IMG_COL = 540,
    parameter int ADDR_W  = 19,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start_i,
    input  logic [SEL_W-1:0]         src_sel_i,
    input  logic [NUM_SRC*PIX_W-1:0] pixel_i,
    input  logic [NUM_SRC-1:0]       pixel_en_i,
    output logic                     ena_o,
    output logic                     wea_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic [PIX_W-1:0]         d2mem_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     collision_o,
    output logic [9:0]               row_o,
    output logic [9:0]               col_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [SEL_W:0] NSRC     = NUM_SRC[SEL_W:0];
    localparam logic [9:0]     ROW_LAST = 10'(IMG_ROW - 1);
    localparam logic [9:0]     COL_LAST = 10'(IMG_COL - 1);

    logic [1:0]         state;
    logic [SEL_W-1:0]   sel;
    logic [9:0]         row;
    logic [9:0]         col;
    logic [ADDR_W-1:0]  addr;
    logic               wr;

    logic               sel_ok;
    logic               start;
    logic               en_sel;
    logic               multi;
    logic               last;
    logic [NUM_SRC-1:0] en_vec;
    logic [NUM_SRC*PIX_W-1:0] pix_vec;
    logic [PIX_W-1:0]   pix_sel;

    always_comb begin
        sel_ok  = ({1'b0, src_sel_i} < NSRC);
        start   = frame_start_i && sel_ok;
        en_vec  = pixel_en_i >> sel;
        en_sel  = en_vec[0];
        pix_vec = pixel_i >> (sel * PIX_W);
        pix_sel = pix_vec[PIX_W-1:0];
        // two or more bits set <=> clearing the lowest set bit leaves some
        multi   = |(pixel_en_i & (pixel_en_i - 1'b1));
        last    = (row == ROW_LAST) && (col == COL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            row         <= '0;
            col         <= '0;
            addr        <= '0;
            wr          <= 1'b0;
            addr_o      <= '0;
            d2mem_o     <= '0;
            collision_o <= 1'b0;
        end else begin
            wr      <= 1'b0;
            d2mem_o <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        sel         <= src_sel_i;
                        row         <= '0;
                        col         <= '0;
                        addr        <= '0;
                        collision_o <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        // restart drops any pixel arriving this cycle
                        sel         <= src_sel_i;
                        row         <= '0;
                        col         <= '0;
                        addr        <= '0;
                        collision_o <= 1'b0;
                    end else begin
                        if (multi)
                            collision_o <= 1'b1;
                        if (en_sel) begin
                            wr      <= 1'b1;
                            addr_o  <= addr;
                            d2mem_o <= pix_sel;
                            if (last) begin
                                // counters stay parked on the final pixel
                                state <= DONE;
                            end else begin
                                addr <= addr + 1'b1;
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ena_o        = wr;
    assign wea_o        = wr;
    assign busy_o       = (state == RUN);
    assign frame_done_o = (state == DONE);
    assign row_o        = row;
    assign col_o        = col;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer on a 4x3 frame with two sources.
// Inputs change at negedge; outputs are sampled at the following negedge.
module tb_pixel_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start_i;
    logic [1:0]  src_sel_i;
    logic [15:0] pixel_i;
    logic [1:0]  pixel_en_i;
    logic        ena_o;
    logic        wea_o;
    logic [18:0] addr_o;
    logic [7:0]  d2mem_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        collision_o;
    logic [9:0]  row_o;
    logic [9:0]  col_o;

    int checks = 0;
    int errors = 0;
    int writes;
    int dones;

    pixel_frame_writer #(
        .NUM_SRC(2), .PIX_W(8), .IMG_ROW(4), .IMG_COL(3),
        .ADDR_W(19), .SEL_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start_i(frame_start_i), .src_sel_i(src_sel_i),
        .pixel_i(pixel_i), .pixel_en_i(pixel_en_i),
        .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o),
        .d2mem_o(d2mem_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .collision_o(collision_o),
        .row_o(row_o), .col_o(col_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (ena_o) writes++;
        if (frame_done_o) dones++;
    endtask

    task automatic idle_in();
        frame_start_i = 1'b0;
        pixel_en_i    = 2'b00;
        pixel_i       = 16'h0000;
    endtask

    task automatic start(input logic [1:0] s);
        frame_start_i = 1'b1;
        src_sel_i     = s;
        step();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle_in();
        src_sel_i = 2'd0;
        rst_n     = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ena", {31'd0, ena_o}, 32'd0);
        chk("rst_addr", {13'd0, addr_o}, 32'd0);
        chk("rst_d2mem", {24'd0, d2mem_o}, 32'd0);
        chk("rst_done", {31'd0, frame_done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // full frame on source 1, back-to-back
        writes = 0; dones = 0;
        start(2'd1);
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        chk("t1_nowr", {31'd0, ena_o}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            pixel_i    = {8'(8'h10 + i), 8'hEE};
            pixel_en_i = 2'b10;
            step();
            chk("t1_ena", {30'd0, wea_o, ena_o}, 32'd3);
            chk("t1_addr", {13'd0, addr_o}, i);
            chk("t1_data", {24'd0, d2mem_o}, 32'h10 + i);
            chk("t1_done", {31'd0, frame_done_o}, (i == 11) ? 1 : 0);
            if (i == 2) begin
                chk("t1_wrap_col", {22'd0, col_o}, 32'd0);
                chk("t1_wrap_row", {22'd0, row_o}, 32'd1);
            end
        end
        idle_in();
        step();
        chk("t1_busy_end", {31'd0, busy_o}, 32'd0);
        chk("t1_ena_end", {31'd0, ena_o}, 32'd0);
        chk("t1_dones", dones, 32'd1);
        chk("t1_writes", writes, 32'd12);
        chk("t1_row_fin", {22'd0, row_o}, 32'd3);
        chk("t1_col_fin", {22'd0, col_o}, 32'd2);
        chk("t1_addr_fin", {13'd0, addr_o}, 32'd11);

        // collision: both sources valid, source 0 selected
        start(2'd0);
        pixel_i    = 16'h55AA;
        pixel_en_i = 2'b11;
        step();
        chk("t2_data", {24'd0, d2mem_o}, 32'hAA);
        chk("t2_coll", {31'd0, collision_o}, 32'd1);
        idle_in();
        step();
        chk("t2_coll_hold", {31'd0, collision_o}, 32'd1);
        chk("t2_d2mem_zero", {24'd0, d2mem_o}, 32'd0);
        start(2'd0);
        chk("t2_coll_clr", {31'd0, collision_o}, 32'd0);

        // abort after 5 pixels, restart on source 1
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            pixel_i    = 16'h0030 + 16'(i);
            pixel_en_i = 2'b01;
            step();
        end
        chk("t3_col5", {22'd0, col_o}, 32'd2);
        pixel_i       = 16'h7700;
        pixel_en_i    = 2'b10;
        frame_start_i = 1'b1;
        src_sel_i     = 2'd1;
        step();
        frame_start_i = 1'b0;
        chk("t3_discard", {31'd0, ena_o}, 32'd0);
        chk("t3_row0", {22'd0, row_o}, 32'd0);
        chk("t3_col0", {22'd0, col_o}, 32'd0);
        pixel_i    = 16'h6600;
        pixel_en_i = 2'b10;
        step();
        chk("t3_addr0", {13'd0, addr_o}, 32'd0);
        chk("t3_data", {24'd0, d2mem_o}, 32'h66);
        chk("t3_nodone", dones, 32'd0);
        do_reset();

        // gapped enables on source 0
        writes = 0; dones = 0;
        start(2'd0);
        for (int i = 0; i < 12; i++) begin
            pixel_i    = 16'h0040 + 16'(i);
            pixel_en_i = 2'b01;
            step();
            if (i == 2) begin
                chk("t4_col", {22'd0, col_o}, 32'd0);
                chk("t4_row", {22'd0, row_o}, 32'd1);
            end
            if (i == 3)
                chk("t4_addr3", {13'd0, addr_o}, 32'd3);
            idle_in();
            step();
            step();
        end
        chk("t4_writes", writes, 32'd12);
        chk("t4_dones", dones, 32'd1);

        // invalid select keeps the block idle
        writes = 0;
        start(2'd3);
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        pixel_i    = 16'h1234;
        pixel_en_i = 2'b11;
        step();
        step();
        idle_in();
        chk("t5_writes", writes, 32'd0);

        // asynchronous reset mid-frame at address 7
        start(2'd0);
        for (int i = 0; i < 7; i++) begin
            pixel_i    = 16'h0050 + 16'(i);
            pixel_en_i = 2'b01;
            step();
        end
        chk("t6_pre_addr", {13'd0, addr_o}, 32'd6);
        pixel_i    = 16'h0099;
        pixel_en_i = 2'b01;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_ena", {30'd0, wea_o, ena_o}, 32'd0);
        chk("t6_addr", {13'd0, addr_o}, 32'd0);
        chk("t6_rowcol", {12'd0, row_o, col_o}, 32'd0);
        chk("t6_data", {24'd0, d2mem_o}, 32'd0);
        writes = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("t6_post_wr", writes, 32'd0);
        chk("t6_post_busy", {31'd0, busy_o}, 32'd0);
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of pixel sources.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-003 SHALL have parameter IMG_ROW, default 540: frame rows.
REQ-004 SHALL have parameter IMG_COL, default 540: frame columns.
REQ-005 SHALL have parameter ADDR_W, default 19: BRAM address width; ADDR_W >= clog2(IMG_ROW*IMG_COL).
REQ-006 SHALL have parameter SEL_W, default 2: source-select width; 2**SEL_W >= NUM_SRC.
REQ-007 SHALL have port clk, input, 1: single clock.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port frame_start_i, input, 1: start or restart one frame.
REQ-010 SHALL have port src_sel_i, input, SEL_W: source index, sampled at frame start.
REQ-011 SHALL have port pixel_i, input, NUM_SRC*PIX_W: source k occupies bits [k*PIX_W +: PIX_W].
REQ-012 SHALL have port pixel_en_i, input, NUM_SRC: per-source pixel valid.
REQ-013 SHALL have port ena_o, input-side BRAM enable, output, 1.
REQ-014 SHALL have port wea_o, output, 1: BRAM write enable.
REQ-015 SHALL have port addr_o, output, ADDR_W: BRAM address.
REQ-016 SHALL have port d2mem_o, output, PIX_W: BRAM write data.
REQ-017 SHALL have ports busy_o (1), frame_done_o (1), collision_o (1), row_o (10), col_o (10), all outputs.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; reset state IDLE.
REQ-019 SHALL, in IDLE, on frame_start_i=1 with src_sel_i < NUM_SRC: latch sel, clear row/col/addr to 0, clear collision_o, enter RUN next cycle.
REQ-020 SHALL ignore frame_start_i with src_sel_i >= NUM_SRC; remain IDLE.
REQ-021 SHALL, in RUN, on pixel_en_i[sel]=1, assert ena_o=wea_o=1 for exactly the following cycle, with addr_o = current address and d2mem_o = pixel_i slice of sel (1-cycle latency).
REQ-022 SHALL ignore pixel_en_i of non-selected sources for writing.
REQ-023 SHALL advance after each accepted pixel: col+1; at col=IMG_COL-1 col wraps to 0 and row+1; addr+1.
REQ-024 SHALL, on accepting pixel at row=IMG_ROW-1, col=IMG_COL-1, enter DONE; that write still issues.
REQ-025 SHALL, in DONE, pulse frame_done_o high for exactly one cycle, then return to IDLE with row/col/addr held at final values.
REQ-026 SHALL set collision_o sticky high when, in RUN, two or more pixel_en_i bits are 1 in the same cycle; selected source still written.
REQ-027 SHALL, on frame_start_i=1 in RUN with valid src_sel_i, abort: re-latch sel, reset row/col/addr to 0, stay RUN; a pixel in the same cycle is discarded.
REQ-028 SHALL ignore frame_start_i in DONE.
REQ-029 SHALL ignore all pixel_en_i in IDLE and DONE; no write issued.
REQ-030 SHALL drive busy_o=1 exactly while in RUN.
REQ-031 SHALL drive row_o/col_o as current row/column counters, zero-extended to 10 bits.
REQ-032 SHALL drive ena_o=wea_o=0 and d2mem_o=0 in all cycles without a write.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously force IDLE and all outputs, counters, latched sel and collision_o to 0.
REQ-034 SHALL, on reset mid-RUN, discard any pending write; no write on first cycle after release.

Verification (IMG_ROW=4, IMG_COL=3, NUM_SRC=2)
REQ-035 SHALL verify: start sel=1, 12 pixels 0x10..0x1B on src1 back-to-back -> writes addr 0..11 data 0x10..0x1B, 1-cycle latency, single frame_done_o pulse after addr 11, busy_o low after.
REQ-036 SHALL verify: sel=0, pixel_en_i=2'b11 with src0=0xAA, src1=0x55 -> write 0xAA, collision_o=1 until next start.
REQ-037 SHALL verify: 5 pixels then frame_start_i sel=1 -> next write at addr 0, row_o=col_o=0, no frame_done_o.
REQ-038 SHALL verify: gapped enables (1 of 3 cycles) on src0 -> col wraps 2->0 with row 0->1 at addr 3; 12 writes total.
REQ-039 SHALL verify: start with src_sel_i=3 -> stays IDLE, busy_o=0, no writes; pixels in IDLE produce no ena_o.
REQ-040 SHALL verify: rst_n low at addr 7 mid-RUN -> all outputs 0 immediately; after release IDLE, no write until new start.
